instr_fetch_stage: RTL and testbench

- Fetch stage directly downstream of the program counter.
- Accepts the PC value (PresentState) with a valid/ready handshake and issues one word read to instruction memory, which has variable latency.
- Holds the returned instruction plus PC+4 in a single IF/ID output slot for the decode stage.
- Supports back-pressure from decode and a branch flush that discards in-flight work.

---
 rtl/mips_fetch_pkg.sv | 22 ++
 rtl/instr_fetch_stage_if.sv | 33 +++
 rtl/if_id_slot.sv | 43 ++++
 rtl/instr_fetch_stage.sv | 120 ++++++++++++
 tb/tb_instr_fetch_stage.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_fetch_pkg.sv
// Purpose : shared types and constants for the instruction fetch stage.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: fetch_state_t FSM encoding, default NOP word, PC increment,
//           low-address-bit mask used for word alignment.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,    // ready to accept a PC when the output slot allows
        WAIT = 2'd1,    // one read outstanding, result goes to the slot
        DROP = 2'd2     // one read outstanding, result is thrown away
    } fetch_state_t;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    localparam int PC_INCR = 4;

    // Byte-offset bits inside a 32-bit instruction word.
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Purpose : PC / instruction-memory / decode handshake bundle for fetch.
// Latency : n/a (wires only).
// Backpr. : PCReady toward the PC, IDReady from decode.
// Ports   : slave = fetch stage side, master = environment side
//           (PC source, instruction memory, decode).
interface instr_fetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] PC;
    logic              PCValid;
    logic              PCReady;
    logic              Flush;
    logic              MemReq;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemRdValid;
    logic [DATA_W-1:0] MemRdData;
    logic              IDValid;
    logic              IDReady;
    logic [DATA_W-1:0] IDInstr;
    logic [ADDR_W-1:0] IDPCPlus4;
    logic              AlignErr;

    modport slave (
        input  PC, PCValid, Flush, MemRdValid, MemRdData, IDReady,
        output PCReady, MemReq, MemAddr, IDValid, IDInstr, IDPCPlus4, AlignErr
    );

    modport master (
        output PC, PCValid, Flush, MemRdValid, MemRdData, IDReady,
        input  PCReady, MemReq, MemAddr, IDValid, IDInstr, IDPCPlus4, AlignErr
    );
endinterface

// File: rtl/if_id_slot.sv
// Purpose : single-entry IF/ID register holding instruction and PC+4.
// Latency : load visible one cycle after the load strobe.
// Backpr. : contents held while valid && !consume; load beats consume,
//           flush clears unless the same cycle loads.
// Ports   : clk/reset (sync, active-high), load + load_instr/load_pc4,
//           consume (decode ready), flush, outputs valid/instr/pc4.
module if_id_slot #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_instr,
    input  logic [ADDR_W-1:0] load_pc4,
    input  logic              consume,
    input  logic              flush,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc4
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= DATA_W'(NOP_INSTR);
            pc4   <= '0;
        end else begin
            if (load) begin
                instr <= load_instr;
                pc4   <= load_pc4;
            end
            // The caller never asserts load together with a flush that
            // kills it, so a load here always survives.
            if (load)
                valid <= 1'b1;
            else if (flush || (consume && valid))
                valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Purpose : fetch stage; takes a PC, issues one word read, parks the result
//           plus PC+4 in the IF/ID slot. Optional ALIGN_CHECK_EN macro adds
//           misaligned-PC trapping (NOP injected, sticky AlignErr).
// Latency : PC accepted at n -> IDValid at n + mem latency + 1; one read max.
// Backpr. : PC only accepted when the slot is empty or drained that cycle;
//           Flush kills in-flight read (DROP) and clears the slot.
// Ports   : Clk, Reset (sync, active-high), bus (instr_fetch_stage_if.slave).
module instr_fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Reset,
    instr_fetch_stage_if.slave    bus
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(WORD_ALIGN_MASK);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] req_pc;
    logic              pc_ready;
    logic              mem_req;
    logic              misalign;
    logic              load;
    logic [DATA_W-1:0] load_instr;
    logic [ADDR_W-1:0] load_pc4;

`ifdef ALIGN_CHECK_EN
    logic align_err;

    assign misalign = (bus.PC[1:0] & WORD_ALIGN_MASK) != 2'b00;

    always_ff @(posedge Clk) begin
        if (Reset)
            align_err <= 1'b0;
        else if (bus.PCValid && pc_ready && misalign)
            align_err <= 1'b1;
    end

    assign bus.AlignErr = align_err;
`else
    assign misalign     = 1'b0;
    assign bus.AlignErr = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            req_pc <= '0;
        end else begin
            state <= state_nxt;
            if (mem_req)
                req_pc <= bus.PC;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_ready   = 1'b0;
        mem_req    = 1'b0;
        load       = 1'b0;
        load_instr = bus.MemRdData;
        load_pc4   = req_pc + ADDR_W'(PC_INCR);
        case (state)
            IDLE: begin
                // Slot must be free (or draining now) before we ask memory,
                // so a response can never find the slot occupied.
                pc_ready = !Reset && !bus.Flush && (!bus.IDValid || bus.IDReady);
                if (bus.PCValid && pc_ready) begin
                    if (misalign) begin
                        load       = 1'b1;
                        load_instr = DATA_W'(NOP_INSTR);
                        load_pc4   = bus.PC + ADDR_W'(PC_INCR);
                    end else begin
                        mem_req   = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.MemRdValid) begin
                    load      = !bus.Flush;
                    state_nxt = IDLE;
                end else if (bus.Flush) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (bus.MemRdValid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.PCReady = pc_ready;
    assign bus.MemReq  = mem_req;
    assign bus.MemAddr = mem_req ? (bus.PC & ADDR_MASK) : '0;

    if_id_slot #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_slot (
        .clk        (Clk),
        .reset      (Reset),
        .load       (load),
        .load_instr (load_instr),
        .load_pc4   (load_pc4),
        .consume    (bus.IDReady),
        .flush      (bus.Flush),
        .valid      (bus.IDValid),
        .instr      (bus.IDInstr),
        .pc4        (bus.IDPCPlus4)
    );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Purpose : directed self-checking bench for instr_fetch_stage.
// Latency : inputs driven 1ns after each rising edge, checked 1ns later.
// Backpr. : memory and decode behaviour scripted step by step.
module tb_instr_fetch_stage;
    import mips_fetch_pkg::*;

    logic Clk;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;

    instr_fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    instr_fetch_stage #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_if.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        Reset             = 1'b1;
        bus_if.PC         = '0;
        bus_if.PCValid    = 1'b0;
        bus_if.Flush      = 1'b0;
        bus_if.MemRdValid = 1'b0;
        bus_if.MemRdData  = '0;
        bus_if.IDReady    = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        settle();
        chk("rst_pcready",  bus_if.PCReady,   0);
        chk("rst_memreq",   bus_if.MemReq,    0);
        chk("rst_memaddr",  bus_if.MemAddr,   0);
        chk("rst_idvalid",  bus_if.IDValid,   0);
        chk("rst_idinstr",  bus_if.IDInstr,   32'h0000_0000);
        chk("rst_idpc4",    bus_if.IDPCPlus4, 0);
        chk("rst_alignerr", bus_if.AlignErr,  0);

        // ---- basic fetch, 1-cycle memory ----
        Reset          = 1'b0;
        bus_if.PC      = 32'h0040_0000;
        bus_if.PCValid = 1'b1;
        settle();
        chk("f1_pcready", bus_if.PCReady, 1);
        chk("f1_memreq",  bus_if.MemReq,  1);
        chk("f1_memaddr", bus_if.MemAddr, 32'h0040_0000);
        tick();
        bus_if.PCValid    = 1'b0;
        bus_if.MemRdValid = 1'b1;
        bus_if.MemRdData  = 32'h8C08_0004;
        settle();
        chk("f1_wait_pcready", bus_if.PCReady, 0);
        chk("f1_wait_memreq",  bus_if.MemReq,  0);
        chk("f1_wait_idvalid", bus_if.IDValid, 0);
        tick();
        bus_if.MemRdValid = 1'b0;
        // ---- backpressure: slot full, decode stalled ----
        bus_if.PC      = 32'h0040_0004;
        bus_if.PCValid = 1'b1;
        settle();
        chk("f1_idvalid", bus_if.IDValid,   1);
        chk("f1_idinstr", bus_if.IDInstr,   32'h8C08_0004);
        chk("f1_idpc4",   bus_if.IDPCPlus4, 32'h0040_0004);
        chk("bp_pcready", bus_if.PCReady,   0);
        chk("bp_memreq",  bus_if.MemReq,    0);
        tick();
        settle();
        chk("bp_hold_instr",   bus_if.IDInstr, 32'h8C08_0004);
        chk("bp_hold_valid",   bus_if.IDValid, 1);
        chk("bp_hold_pcready", bus_if.PCReady, 0);
        bus_if.IDReady = 1'b1;
        settle();
        chk("bp_release_pcready", bus_if.PCReady, 1);
        chk("bp_release_memreq",  bus_if.MemReq,  1);
        chk("bp_release_memaddr", bus_if.MemAddr, 32'h0040_0004);
        tick();
        // ---- flush during a 4-cycle read: MemReq was at m, now m+1 ----
        bus_if.PCValid = 1'b0;
        bus_if.IDReady = 1'b0;
        settle();
        chk("drain_idvalid", bus_if.IDValid, 0);
        chk("m1_state",      dut.state,      WAIT);
        tick();
        bus_if.Flush = 1'b1;
        settle();
        chk("m2_pcready", bus_if.PCReady, 0);
        tick();
        bus_if.Flush = 1'b0;
        settle();
        chk("m3_state",   dut.state,      DROP);
        chk("m3_pcready", bus_if.PCReady, 0);
        chk("m3_idvalid", bus_if.IDValid, 0);
        tick();
        bus_if.MemRdValid = 1'b1;
        bus_if.MemRdData  = 32'h1234_5678;
        settle();
        chk("m4_pcready", bus_if.PCReady, 0);
        tick();
        bus_if.MemRdValid = 1'b0;
        bus_if.PC         = 32'h0040_0008;
        bus_if.PCValid    = 1'b1;
        settle();
        chk("drop_idvalid", bus_if.IDValid, 0);
        chk("drop_state",   dut.state,      IDLE);
        chk("drop_memreq",  bus_if.MemReq,  1);
        chk("drop_memaddr", bus_if.MemAddr, 32'h0040_0008);
        tick();
        // ---- flush coincident with response ----
        bus_if.PCValid    = 1'b0;
        bus_if.Flush      = 1'b1;
        bus_if.MemRdValid = 1'b1;
        bus_if.MemRdData  = 32'hDEAD_BEEF;
        settle();
        chk("fc_memreq", bus_if.MemReq, 0);
        tick();
        bus_if.Flush      = 1'b0;
        bus_if.MemRdValid = 1'b0;
        bus_if.PC         = 32'h0040_0010;
        bus_if.PCValid    = 1'b1;
        settle();
        chk("fc_idvalid", bus_if.IDValid, 0);
        chk("fc_state",   dut.state,      IDLE);
        chk("fc_pcready", bus_if.PCReady, 1);
        tick();
        bus_if.PCValid    = 1'b0;
        bus_if.MemRdValid = 1'b1;
        bus_if.MemRdData  = 32'h2402_000A;
        tick();
        bus_if.MemRdValid = 1'b0;
        settle();
        chk("fs_idvalid", bus_if.IDValid,   1);
        chk("fs_idpc4",   bus_if.IDPCPlus4, 32'h0040_0014);
        // ---- flush with slot full and decode stalled ----
        bus_if.Flush = 1'b1;
        settle();
        chk("fs_pcready", bus_if.PCReady, 0);
        tick();
        bus_if.Flush = 1'b0;
        settle();
        chk("fs_cleared", bus_if.IDValid, 0);

        // ---- PC+4 wrap ----
        bus_if.PC      = 32'hFFFF_FFFC;
        bus_if.PCValid = 1'b1;
        settle();
        chk("wrap_memreq",  bus_if.MemReq,  1);
        chk("wrap_memaddr", bus_if.MemAddr, 32'hFFFF_FFFC);
        tick();
        bus_if.PCValid    = 1'b0;
        bus_if.MemRdValid = 1'b1;
        bus_if.MemRdData  = 32'h03E0_0008;
        tick();
        bus_if.MemRdValid = 1'b0;
        bus_if.IDReady    = 1'b1;
        settle();
        chk("wrap_idvalid", bus_if.IDValid,   1);
        chk("wrap_idinstr", bus_if.IDInstr,   32'h03E0_0008);
        chk("wrap_idpc4",   bus_if.IDPCPlus4, 32'h0000_0000);
        tick();
        bus_if.IDReady = 1'b0;
        settle();
        chk("wrap_consumed", bus_if.IDValid, 0);

        // ---- reset in the middle of WAIT ----
        bus_if.PC      = 32'h0040_0020;
        bus_if.PCValid = 1'b1;
        settle();
        chk("rw_memreq", bus_if.MemReq, 1);
        tick();
        bus_if.PCValid = 1'b0;
        Reset          = 1'b1;
        settle();
        chk("rw_pcready_in_reset", bus_if.PCReady, 0);
        chk("rw_memreq_in_reset",  bus_if.MemReq,  0);
        tick();
        Reset             = 1'b0;
        bus_if.MemRdValid = 1'b1;
        bus_if.MemRdData  = 32'hFFFF_FFFF;
        settle();
        chk("rw_idvalid", bus_if.IDValid,   0);
        chk("rw_idinstr", bus_if.IDInstr,   32'h0000_0000);
        chk("rw_idpc4",   bus_if.IDPCPlus4, 0);
        chk("rw_state",   dut.state,        IDLE);
        tick();
        bus_if.MemRdValid = 1'b0;
        settle();
        chk("rw_late_ignored", bus_if.IDValid, 0);
        chk("rw_pcready",      bus_if.PCReady, 1);

`ifdef ALIGN_CHECK_EN
        // ---- misaligned PC trapped ----
        bus_if.PC      = 32'h0040_0002;
        bus_if.PCValid = 1'b1;
        settle();
        chk("al_pcready", bus_if.PCReady, 1);
        chk("al_memreq",  bus_if.MemReq,  0);
        tick();
        bus_if.PCValid = 1'b0;
        settle();
        chk("al_idvalid",  bus_if.IDValid,   1);
        chk("al_idinstr",  bus_if.IDInstr,   32'h0000_0000);
        chk("al_idpc4",    bus_if.IDPCPlus4, 32'h0040_0006);
        chk("al_alignerr", bus_if.AlignErr,  1);
        chk("al_state",    dut.state,        IDLE);
        bus_if.IDReady = 1'b1;
        bus_if.PC      = 32'h0040_0030;
        bus_if.PCValid = 1'b1;
        settle();
        chk("al_next_memreq", bus_if.MemReq, 1);
        tick();
        bus_if.IDReady    = 1'b0;
        bus_if.PCValid    = 1'b0;
        bus_if.MemRdValid = 1'b1;
        bus_if.MemRdData  = 32'h1111_1111;
        tick();
        bus_if.MemRdValid = 1'b0;
        settle();
        chk("al_next_idinstr", bus_if.IDInstr,  32'h1111_1111);
        chk("al_sticky",       bus_if.AlignErr, 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        settle();
        chk("al_cleared", bus_if.AlignErr, 0);
`else
        // ---- misaligned PC forced to word address ----
        bus_if.PC      = 32'h0040_0042;
        bus_if.PCValid = 1'b1;
        settle();
        chk("na_memreq",  bus_if.MemReq,  1);
        chk("na_memaddr", bus_if.MemAddr, 32'h0040_0040);
        tick();
        bus_if.PCValid    = 1'b0;
        bus_if.MemRdValid = 1'b1;
        bus_if.MemRdData  = 32'h2222_2222;
        tick();
        bus_if.MemRdValid = 1'b0;
        settle();
        chk("na_idinstr",  bus_if.IDInstr,  32'h2222_2222);
        chk("na_alignerr", bus_if.AlignErr, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
